// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter
// Shares one single-port SRAM (fixed 1-cycle read latency) between the ibex
// instruction and data OBI ports.
//   - Arbitration and grant are combinational and happen in the same cycle.
//   - Instruction fetches normally win. A run counter limits how many fetches
//     in a row can be granted while a load/store waits, so data is never starved.
//   - Addresses outside the SRAM window are still granted, but they never reach
//     the SRAM and they return an error response.
//   - Each grant produces exactly one response on the owning port one cycle later.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   instr_*                   fetch port (req/addr in; gnt/rvalid/rdata/err out)
//   data_*                    load/store port (req/we/be/addr/wdata in;
//                             gnt/rvalid/rdata/err out)
//   mem_*                     SRAM side (req/we/be/addr/wdata out; rdata in)
module ibex_mem_arbiter #(
    parameter logic [31:0] MemStart    = 32'h0000_0000,
    parameter int unsigned MemSize     = 8192,
    parameter int unsigned MaxInstrRun = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [31:0] OffMask = 32'(MemSize - 1);
    localparam logic [3:0]  RunMax  = 4'(MaxInstrRun);

    typedef enum logic {
        OwnerInstr = 1'b0,
        OwnerData  = 1'b1
    } owner_e;

    logic [3:0]  run_q, run_d;
    logic        resp_valid_q, resp_valid_d;
    owner_e      resp_owner_q, resp_owner_d;
    logic        resp_err_q, resp_err_d;
    logic        resp_we_q, resp_we_d;

    logic        sel_data, sel_instr, any_gnt, hit;
    logic [31:0] win_addr;

    // Grant and SRAM request path. Everything is forced idle while reset is
    // held, so a request during reset is never accepted.
    always_comb begin
        sel_data    = data_req_i & (~instr_req_i | (run_q == RunMax));
        sel_instr   = instr_req_i & ~sel_data;
        if (rst_i) begin
            sel_data  = 1'b0;
            sel_instr = 1'b0;
        end
        any_gnt     = sel_data | sel_instr;
        win_addr    = sel_data ? data_addr_i : instr_addr_i;
        hit         = (win_addr & ~OffMask) == MemStart;

        instr_gnt_o = sel_instr;
        data_gnt_o  = sel_data;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if (any_gnt && hit) begin
            mem_req_o  = 1'b1;
            mem_addr_o = win_addr & OffMask;
            if (sel_data) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o    = 4'hF;
            end
        end
    end

    // Next state for the run counter and the response register.
    always_comb begin
        run_d        = run_q;
        resp_valid_d = any_gnt;
        resp_owner_d = resp_owner_q;
        resp_err_d   = resp_err_q;
        resp_we_d    = resp_we_q;
        if (sel_data || !data_req_i) begin
            run_d = 4'd0;
        end else if (sel_instr && run_q != RunMax) begin
            run_d = run_q + 4'd1;
        end
        if (any_gnt) begin
            resp_owner_d = sel_data ? OwnerData : OwnerInstr;
            resp_err_d   = ~hit;
            resp_we_d    = sel_data & data_we_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_q        <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_owner_q <= OwnerInstr;
            resp_err_q   <= 1'b0;
            resp_we_q    <= 1'b0;
        end else begin
            run_q        <= run_d;
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
            resp_err_q   <= resp_err_d;
            resp_we_q    <= resp_we_d;
        end
    end

    // The response is suppressed while reset is high, so a grant taken just
    // before reset never shows up. Stores and errors return zero data.
    logic        resp_live;
    logic [31:0] resp_data;

    always_comb begin
        resp_live      = resp_valid_q & ~rst_i;
        resp_data      = (resp_err_q || resp_we_q) ? 32'h0 : mem_rdata_i;
        instr_rvalid_o = resp_live & (resp_owner_q == OwnerInstr);
        data_rvalid_o  = resp_live & (resp_owner_q == OwnerData);
        instr_err_o    = instr_rvalid_o & resp_err_q;
        data_err_o     = data_rvalid_o & resp_err_q;
        instr_rdata_o  = instr_rvalid_o ? resp_data : 32'h0;
        data_rdata_o   = data_rvalid_o ? resp_data : 32'h0;
    end

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Scoreboard bench for ibex_mem_arbiter. The driver applies one request set
// per cycle, checks the grant and SRAM strobes, and queues the response it
// expects. A negedge monitor compares both response ports every cycle.
module tb_ibex_mem_arbiter;

    localparam int MEM_SIZE = 8192;
    localparam int MAX_RUN  = 4;
    localparam longint MEM_START = 0;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [31:0] mem_rdata_i;

    always #5 clk_i = ~clk_i;

    ibex_mem_arbiter #(
        .MemStart    (32'h0000_0000),
        .MemSize     (MEM_SIZE),
        .MaxInstrRun (MAX_RUN)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i)
    );

    // SRAM behavioural model: 1-cycle read latency, byte-enabled writes.
    logic [31:0] sram [0:2047];
    always @(posedge clk_i) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) sram[mem_addr_o[12:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                mem_rdata_i <= sram[mem_addr_o[12:2]];
            end
        end
    end

    typedef struct {
        int          due;
        bit          owner;   // 1 = data port
        bit          err;
        logic [31:0] rdata;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] model_mem [0:2047];
    int          wait_cnt = 0;   // consecutive fetch grants while a data request waited
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    always @(posedge clk_i) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit in_window(input logic [31:0] a);
        return (64'(a) >= MEM_START) && (64'(a) < MEM_START + MEM_SIZE);
    endfunction

    // One cycle of stimulus plus the reference prediction for it.
    task automatic step(input bit rst, input bit ir, input logic [31:0] ia,
                        input bit dr, input bit we, input logic [3:0] be,
                        input logic [31:0] da, input logic [31:0] wd);
        bit          g_i, g_d, ok;
        logic [31:0] a, off;
        logic [69:0] exp_mem;
        resp_t       r;
        @(posedge clk_i);
        #1;
        rst_i = rst; instr_req_i = ir; instr_addr_i = ia;
        data_req_i = dr; data_we_i = we; data_be_i = be;
        data_addr_i = da; data_wdata_i = wd;
        #1;
        g_i = 1'b0;
        g_d = 1'b0;
        if (rst) begin
            exp_q.delete();
            wait_cnt = 0;
        end else begin
            g_d = dr && (!ir || wait_cnt >= MAX_RUN);
            g_i = ir && !g_d;
        end
        check("gnt", 128'({instr_gnt_o, data_gnt_o}), 128'({g_i, g_d}));

        a       = g_d ? da : ia;
        ok      = in_window(a);
        off     = 32'(64'(a) - MEM_START);
        exp_mem = '0;
        if ((g_i || g_d) && ok)
            exp_mem = {1'b1, g_d && we, g_d ? be : 4'hF, off, g_d ? wd : 32'h0};
        check("mem_side", 128'({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o}),
              128'(exp_mem));

        if (g_i || g_d) begin
            r.due   = cyc + 1;
            r.owner = g_d;
            r.err   = !ok;
            r.rdata = (!ok || (g_d && we)) ? 32'h0 : model_mem[off[12:2]];
            exp_q.push_back(r);
            if (ok && g_d && we)
                for (int b = 0; b < 4; b++)
                    if (be[b]) model_mem[off[12:2]][8*b +: 8] = wd[8*b +: 8];
        end
        if (!rst) begin
            if (!dr || g_d) wait_cnt = 0;
            else if (wait_cnt < MAX_RUN) wait_cnt++;
        end
    endtask

    // Response monitor: every cycle both ports must match the queued expectation.
    resp_t       m_e;
    logic [67:0] m_exp;
    always @(negedge clk_i) begin
        m_exp = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            m_e = exp_q.pop_front();
            if (m_e.owner) m_exp[33:0]  = {1'b1, m_e.err, m_e.rdata};
            else           m_exp[67:34] = {1'b1, m_e.err, m_e.rdata};
        end
        check("resp", 128'({instr_rvalid_o, instr_err_o, instr_rdata_o,
                            data_rvalid_o, data_err_o, data_rdata_o}), 128'(m_exp));
    end

    function automatic logic [31:0] rnd_addr();
        logic [31:0] w;
        w = 32'($urandom_range(0, 15)) << 2;
        case ($urandom_range(0, 9))
            0: return 32'h0000_2000 + w;
            1: return 32'h8000_0000 | w;
            2: return 32'h0000_1FFC;
            3: return 32'h0000_1FC0 + w;
            default: return w;
        endcase
    endfunction

    logic [11:0] pat;

    initial begin
        rst_i = 1'b1; instr_req_i = 1'b0; instr_addr_i = '0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = '0;
        data_addr_i = '0; data_wdata_i = '0;
        for (int i = 0; i < 2048; i++) begin
            sram[i]      = 32'h0;
            model_mem[i] = 32'h0;
        end

        // Reset held with both requests high, then release.
        repeat (3) step(1, 1, 32'h40, 1, 0, 4'hF, 32'h44, 32'h0);
        step(0, 1, 32'h40, 1, 0, 4'hF, 32'h44, 32'h0);
        check("reset_release_instr_first", 128'(instr_gnt_o), 128'(1'b1));

        // Partial store then read-back.
        step(0, 0, 32'h0, 1, 1, 4'h3, 32'h0000_0100, 32'hDEADBEEF);
        check("store_mem_strobe", 128'({mem_req_o, mem_we_o, mem_addr_o, mem_be_o}),
              128'({1'b1, 1'b1, 32'h100, 4'h3}));
        step(0, 0, 32'h0, 1, 0, 4'hF, 32'h0000_0100, 32'h0);
        step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        check("load_back", 128'({data_rvalid_o, data_rdata_o}), 128'({1'b1, 32'h0000BEEF}));

        // Fairness: both requesting for 12 cycles from a cleared run counter.
        step(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 32'(i * 4), 1, 0, 4'hF, 32'h0000_0100, 32'h0);
            pat[i] = data_gnt_o;
        end
        check("grant_pattern", 128'(pat), 128'(12'h210));

        // Window boundary on the fetch port.
        step(0, 1, 32'h0000_2000, 0, 0, 4'h0, 32'h0, 32'h0);
        check("fetch_miss_no_mem", 128'({instr_gnt_o, mem_req_o}), 128'({1'b1, 1'b0}));
        step(0, 1, 32'h0000_1FFC, 0, 0, 4'h0, 32'h0, 32'h0);
        check("fetch_miss_err", 128'({instr_rvalid_o, instr_err_o, instr_rdata_o}),
              128'({1'b1, 1'b1, 32'h0}));
        step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

        // Out-of-window store must not touch the RAM.
        step(0, 0, 32'h0, 1, 1, 4'hF, 32'h8000_0000, 32'hFFFF_FFFF);
        check("store_miss_no_mem", 128'({data_gnt_o, mem_req_o, mem_we_o}), 128'(3'b100));
        step(0, 0, 32'h0, 1, 0, 4'hF, 32'h0000_0000, 32'h0);
        step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

        // Reset right after a data grant; then reset after a long fetch run.
        step(0, 0, 32'h0, 1, 1, 4'hF, 32'h0000_0010, 32'h1234_5678);
        step(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        repeat (4) step(0, 1, 32'h8, 1, 0, 4'hF, 32'h10, 32'h0);
        step(1, 1, 32'h8, 1, 0, 4'hF, 32'h10, 32'h0);
        step(0, 1, 32'h8, 1, 0, 4'hF, 32'h10, 32'h0);
        check("run_cleared_by_reset", 128'({instr_gnt_o, data_gnt_o}), 128'(2'b10));

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) < 7, rnd_addr(),
                 $urandom_range(0, 9) < 5, $urandom_range(0, 1) == 1,
                 4'($urandom_range(1, 15)), rnd_addr(), $urandom());
        end
        repeat (2) step(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        @(posedge clk_i);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
